control_unit: RTL and testbench

- Hardwired multi-cycle sequencer that drives every control input of the 32-bit bus datapath: fetch, decode and execute of register-register ALU instructions.
- Sits directly upstream of the datapath. Reads IRVal back from it and drives all of its register enables, bus-out selects and ALU op strobes.
- Memory reads stall on a `mem_ready` handshake.

---
 rtl/control_pkg.sv | 52 +++++
 rtl/control_unit_reg_decoder.sv | 17 +
 rtl/control_unit.sv | 180 ++++++++++++++++++
 tb/tb_control_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and constants for the hardwired sequencer: FSM states,
// opcode values, instruction field positions and small opcode classifiers.
package control_pkg;

   typedef enum logic [2:0] {
      T0, T1, T2, T3, T4, T5, T6, HALTED
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_AND  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_SHR  = 5'd4;
   localparam logic [4:0] OP_SHL  = 5'd5;
   localparam logic [4:0] OP_ROR  = 5'd6;
   localparam logic [4:0] OP_ROL  = 5'd7;
   localparam logic [4:0] OP_MUL  = 5'd8;
   localparam logic [4:0] OP_DIV  = 5'd9;
   localparam logic [4:0] OP_NEG  = 5'd10;
   localparam logic [4:0] OP_NOT  = 5'd11;
   localparam logic [4:0] OP_MFHI = 5'd12;
   localparam logic [4:0] OP_MFLO = 5'd13;
   localparam logic [4:0] OP_NOP  = 5'd14;
   localparam logic [4:0] OP_HALT = 5'd15;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   // Bit positions of the ALU strobes inside the internal strobe vector.
   localparam int S_ADD = 0, S_SUB = 1, S_MUL = 2, S_DIV = 3, S_SHR = 4;
   localparam int S_SHL = 5, S_ROR = 6, S_ROL = 7, S_AND = 8, S_OR = 9;
   localparam int S_NEG = 10, S_NOT = 11, S_INC = 12;

   function automatic logic is_binary(input logic [4:0] op);
      return op <= OP_DIV;
   endfunction

   function automatic logic is_unary(input logic [4:0] op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/control_unit_reg_decoder.sv
// 4-bit register index plus enable to a one-hot register select vector.
module reg_decoder #(
   parameter int REGISTERS = 16
) (
   input  logic [3:0]           idx,
   input  logic                 en,
   output logic [REGISTERS-1:0] onehot
);

   generate
      for (genvar gi = 0; gi < REGISTERS; gi++) begin : g_sel
         localparam logic [3:0] IDX = 4'(gi);
         assign onehot[gi] = en && (idx == IDX);
      end
   endgenerate

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 32-bit bus datapath.
// Optional performance counters are enabled with CONTROL_UNIT_PERF_EN.
module control_unit
   import control_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int REGISTERS = 16,
   parameter int SIG_COUNT = 13
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BITS-1:0]      IRVal,
   input  logic                 mem_ready,
   output logic                 PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin,
   output logic                 Read,
   output logic                 MDRout, LOout, HIout, RZHIout, RZLOout, PCout,
   output logic                 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL,
   output logic                 AND, OR, NEGATE, NOT, IncPC,
   output logic [REGISTERS-1:0] GPRin,
   output logic [REGISTERS-1:0] GPRout,
`ifdef CONTROL_UNIT_PERF_EN
   output logic [31:0]          instr_count,
   output logic [31:0]          stall_count,
`endif
   output logic                 halted,
   output logic                 illegal
);

   state_t                 state_reg, state_next;
   logic                   illegal_reg;
   logic [4:0]             opcode;
   logic [3:0]             ra, rb, rc;
   logic [SIG_COUNT-1:0]   alu_strobe;
   logic                   gin_en, gout_en;
   logic [3:0]             gin_idx, gout_idx;
   logic                   unused_ir;

   assign opcode    = IRVal[OPC_MSB:OPC_LSB];
   assign ra        = IRVal[RA_MSB:RA_LSB];
   assign rb        = IRVal[RB_MSB:RB_LSB];
   assign rc        = IRVal[RC_MSB:RC_LSB];
   assign unused_ir = ^IRVal[RC_LSB-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= T0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == T3 && opcode > OP_HALT)
            illegal_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         T0: state_next = T1;
         T1: state_next = mem_ready ? T2 : T1;
         T2: state_next = T3;
         T3: begin
            if (is_binary(opcode) || is_unary(opcode))
               state_next = T4;
            else if (opcode == OP_MFHI || opcode == OP_MFLO || opcode == OP_NOP)
               state_next = T0;
            else
               state_next = HALTED;
         end
         T4: state_next = T5;
         T5: state_next = is_muldiv(opcode) ? T6 : T0;
         T6: state_next = T0;
         HALTED: state_next = HALTED;
         default: state_next = T0;
      endcase
   end

   // Everything stays quiet while reset is held, even though the state is T0.
   always_comb begin
      {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read} = '0;
      {MDRout, LOout, HIout, RZHIout, RZLOout, PCout}          = '0;
      alu_strobe = '0;
      gin_en     = 1'b0;
      gout_en    = 1'b0;
      gin_idx    = ra;
      gout_idx   = rb;
      halted     = 1'b0;
      if (reset) begin
         unique case (state_reg)
            T0: begin
               PCout = 1'b1; MARin = 1'b1; RZin = 1'b1;
               alu_strobe[S_INC] = 1'b1;
            end
            T1: begin
               RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
               MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
               if (is_binary(opcode)) begin
                  gout_en = 1'b1; RYin = 1'b1;
               end else if (opcode == OP_MFHI) begin
                  HIout = 1'b1; gin_en = 1'b1;
               end else if (opcode == OP_MFLO) begin
                  LOout = 1'b1; gin_en = 1'b1;
               end
            end
            T4: begin
               gout_en  = 1'b1;
               gout_idx = is_unary(opcode) ? rb : rc;
               RZin     = 1'b1;
               case (opcode)
                  OP_ADD: alu_strobe[S_ADD] = 1'b1;
                  OP_SUB: alu_strobe[S_SUB] = 1'b1;
                  OP_AND: alu_strobe[S_AND] = 1'b1;
                  OP_OR:  alu_strobe[S_OR]  = 1'b1;
                  OP_SHR: alu_strobe[S_SHR] = 1'b1;
                  OP_SHL: alu_strobe[S_SHL] = 1'b1;
                  OP_ROR: alu_strobe[S_ROR] = 1'b1;
                  OP_ROL: alu_strobe[S_ROL] = 1'b1;
                  OP_MUL: alu_strobe[S_MUL] = 1'b1;
                  OP_DIV: alu_strobe[S_DIV] = 1'b1;
                  OP_NEG: alu_strobe[S_NEG] = 1'b1;
                  OP_NOT: alu_strobe[S_NOT] = 1'b1;
                  default: ;
               endcase
            end
            T5: begin
               RZLOout = 1'b1;
               if (is_muldiv(opcode)) LOin = 1'b1;
               else                   gin_en = 1'b1;
            end
            T6: begin
               RZHIout = 1'b1; HIin = 1'b1;
            end
            HALTED: halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign illegal = illegal_reg;
   assign ADD    = alu_strobe[S_ADD];
   assign SUB    = alu_strobe[S_SUB];
   assign MUL    = alu_strobe[S_MUL];
   assign DIV    = alu_strobe[S_DIV];
   assign SHR    = alu_strobe[S_SHR];
   assign SHL    = alu_strobe[S_SHL];
   assign ROR    = alu_strobe[S_ROR];
   assign ROL    = alu_strobe[S_ROL];
   assign AND    = alu_strobe[S_AND];
   assign OR     = alu_strobe[S_OR];
   assign NEGATE = alu_strobe[S_NEG];
   assign NOT    = alu_strobe[S_NOT];
   assign IncPC  = alu_strobe[S_INC];

   reg_decoder #(.REGISTERS(REGISTERS)) u_gpr_in (
      .idx(gin_idx), .en(gin_en), .onehot(GPRin)
   );

   reg_decoder #(.REGISTERS(REGISTERS)) u_gpr_out (
      .idx(gout_idx), .en(gout_en), .onehot(GPRout)
   );

`ifdef CONTROL_UNIT_PERF_EN
   // HALTED never enters T0 or T1, so both counters freeze there on their own.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_count <= '0;
         stall_count <= '0;
      end else begin
         if ((state_reg == T3 || state_reg == T5 || state_reg == T6) && state_next == T0)
            instr_count <= instr_count + 32'd1;
         if (state_reg == T1 && !mem_ready)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: one vector per clock cycle, plus
// hand-written reset-mid-stall, illegal-opcode and HALT sequences.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] IRVal = '0;
   logic        mem_ready = 1'b0;
   logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read;
   logic MDRout, LOout, HIout, RZHIout, RZLOout, PCout;
   logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
   logic [15:0] GPRin, GPRout;
   logic halted, illegal;
`ifdef CONTROL_UNIT_PERF_EN
   logic [31:0] instr_count, stall_count;
`endif

   always #5 clk = ~clk;

   control_unit dut (
      .clk(clk), .reset(reset), .IRVal(IRVal), .mem_ready(mem_ready),
      .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
      .HIin(HIin), .LOin(LOin), .MDRin(MDRin), .Read(Read),
      .MDRout(MDRout), .LOout(LOout), .HIout(HIout), .RZHIout(RZHIout),
      .RZLOout(RZLOout), .PCout(PCout),
      .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
      .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
      .IncPC(IncPC), .GPRin(GPRin), .GPRout(GPRout),
`ifdef CONTROL_UNIT_PERF_EN
      .instr_count(instr_count), .stall_count(stall_count),
`endif
      .halted(halted), .illegal(illegal)
   );

   logic [29:0] act;
   assign act = {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
                 MDRout, LOout, HIout, RZHIout, RZLOout, PCout,
                 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
                 IncPC, halted, illegal};

   localparam logic [29:0] C_PCIN    = 30'h1 << 29;
   localparam logic [29:0] C_IRIN    = 30'h1 << 28;
   localparam logic [29:0] C_RYIN    = 30'h1 << 27;
   localparam logic [29:0] C_RZIN    = 30'h1 << 26;
   localparam logic [29:0] C_MARIN   = 30'h1 << 25;
   localparam logic [29:0] C_HIIN    = 30'h1 << 24;
   localparam logic [29:0] C_LOIN    = 30'h1 << 23;
   localparam logic [29:0] C_MDRIN   = 30'h1 << 22;
   localparam logic [29:0] C_READ    = 30'h1 << 21;
   localparam logic [29:0] C_MDROUT  = 30'h1 << 20;
   localparam logic [29:0] C_LOOUT   = 30'h1 << 19;
   localparam logic [29:0] C_HIOUT   = 30'h1 << 18;
   localparam logic [29:0] C_RZHIOUT = 30'h1 << 17;
   localparam logic [29:0] C_RZLOOUT = 30'h1 << 16;
   localparam logic [29:0] C_PCOUT   = 30'h1 << 15;
   localparam logic [29:0] C_ADD     = 30'h1 << 14;
   localparam logic [29:0] C_MUL     = 30'h1 << 12;
   localparam logic [29:0] C_DIV     = 30'h1 << 11;
   localparam logic [29:0] C_NEGATE  = 30'h1 << 4;
   localparam logic [29:0] C_NOT     = 30'h1 << 3;
   localparam logic [29:0] C_INCPC   = 30'h1 << 2;
   localparam logic [29:0] C_HALTED  = 30'h1 << 1;
   localparam logic [29:0] C_ILLEGAL = 30'h1;

   localparam logic [29:0] T0_C = C_PCOUT | C_MARIN | C_INCPC | C_RZIN;
   localparam logic [29:0] T1_C = C_RZLOOUT | C_PCIN | C_READ | C_MDRIN;
   localparam logic [29:0] T2_C = C_MDROUT | C_IRIN;

   typedef struct {
      logic [31:0] ir;
      logic        mr;
      logic [29:0] ctrl;
      logic [15:0] gin;
      logic [15:0] gout;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input logic [31:0] ir, input logic mr, input logic [29:0] ctrl,
                      input logic [15:0] gin, input logic [15:0] gout);
      vec_t v;
      v.ir = ir; v.mr = mr; v.ctrl = ctrl; v.gin = gin; v.gout = gout;
      vecs.push_back(v);
   endtask

   // mem_ready is low in T0/T2 to show it is ignored outside T1.
   task automatic add_fetch(input logic [31:0] ir);
      add(ir, 1'b0, T0_C, 16'h0, 16'h0);
      add(ir, 1'b1, T1_C, 16'h0, 16'h0);
      add(ir, 1'b0, T2_C, 16'h0, 16'h0);
   endtask

   task automatic chk(input string name, input logic [29:0] ctrl,
                      input logic [15:0] gin, input logic [15:0] gout);
      n_checks++;
      if (act !== ctrl || GPRin !== gin || GPRout !== gout) begin
         n_fail++;
         $display("FAIL %s: got ctrl=%h gin=%h gout=%h, expected ctrl=%h gin=%h gout=%h",
                  name, act, GPRin, GPRout, ctrl, gin, gout);
      end else begin
         $display("ok   %s: ctrl=%h gin=%h gout=%h", name, act, GPRin, GPRout);
      end
   endtask

   task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end else begin
         $display("ok   %s: %0d", name, got);
      end
   endtask

   initial begin
      // ADD R1,R2,R3
      add_fetch(32'h00918000);
      add(32'h00918000, 1'b0, C_RYIN,          16'h0000, 16'h0004);
      add(32'h00918000, 1'b0, C_ADD | C_RZIN,  16'h0000, 16'h0008);
      add(32'h00918000, 1'b0, C_RZLOOUT,       16'h0002, 16'h0000);
      // MUL R0,R4,R5
      add_fetch(32'h40228000);
      add(32'h40228000, 1'b0, C_RYIN,              16'h0000, 16'h0010);
      add(32'h40228000, 1'b0, C_MUL | C_RZIN,      16'h0000, 16'h0020);
      add(32'h40228000, 1'b0, C_RZLOOUT | C_LOIN,  16'h0000, 16'h0000);
      add(32'h40228000, 1'b0, C_RZHIOUT | C_HIIN,  16'h0000, 16'h0000);
      // NOT R7,R9 with a three-cycle fetch stall
      add(32'h5BC80000, 1'b1, T0_C, 16'h0, 16'h0);
      for (int i = 0; i < 3; i++) add(32'h5BC80000, 1'b0, T1_C, 16'h0, 16'h0);
      add(32'h5BC80000, 1'b1, T1_C, 16'h0, 16'h0);
      add(32'h5BC80000, 1'b1, T2_C, 16'h0, 16'h0);
      add(32'h5BC80000, 1'b1, 30'h0,           16'h0000, 16'h0000);
      add(32'h5BC80000, 1'b1, C_NOT | C_RZIN,  16'h0000, 16'h0200);
      add(32'h5BC80000, 1'b1, C_RZLOOUT,       16'h0080, 16'h0000);
      // MFHI R5, MFLO R15, NOP
      add_fetch(32'h62800000);
      add(32'h62800000, 1'b0, C_HIOUT, 16'h0020, 16'h0000);
      add_fetch(32'h6F800000);
      add(32'h6F800000, 1'b0, C_LOOUT, 16'h8000, 16'h0000);
      add_fetch(32'h70000000);
      add(32'h70000000, 1'b0, 30'h0, 16'h0000, 16'h0000);
      // DIV R2,R2,R2 (all fields equal)
      add_fetch(32'h49110000);
      add(32'h49110000, 1'b0, C_RYIN,              16'h0000, 16'h0004);
      add(32'h49110000, 1'b0, C_DIV | C_RZIN,      16'h0000, 16'h0004);
      add(32'h49110000, 1'b0, C_RZLOOUT | C_LOIN,  16'h0000, 16'h0000);
      add(32'h49110000, 1'b0, C_RZHIOUT | C_HIIN,  16'h0000, 16'h0000);
      // NEG R3,R3
      add_fetch(32'h51980000);
      add(32'h51980000, 1'b0, 30'h0,              16'h0000, 16'h0000);
      add(32'h51980000, 1'b0, C_NEGATE | C_RZIN,  16'h0000, 16'h0008);
      add(32'h51980000, 1'b0, C_RZLOOUT,          16'h0008, 16'h0000);
      add(32'h70000000, 1'b0, T0_C, 16'h0, 16'h0);

      // Reset held: everything quiet
      mem_ready = 1'b1;
      @(negedge clk);
      #1 chk("reset_held", 30'h0, 16'h0, 16'h0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         IRVal     = vecs[i].ir;
         mem_ready = vecs[i].mr;
         #1 chk($sformatf("vec[%0d]", i), vecs[i].ctrl, vecs[i].gin, vecs[i].gout);
         @(negedge clk);
      end
`ifdef CONTROL_UNIT_PERF_EN
      chk_val("instr_count_after_table", instr_count, 32'd8);
      chk_val("stall_count_after_table", stall_count, 32'd3);
`endif

      // Reset during a T1 stall
      mem_ready = 1'b0;
      #1 chk("stall_t1_a", T1_C, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("stall_t1_b", T1_C, 16'h0, 16'h0);
      reset = 1'b0;
      #1 chk("reset_mid_stall", 30'h0, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("reset_mid_stall_hold", 30'h0, 16'h0, 16'h0);
`ifdef CONTROL_UNIT_PERF_EN
      chk_val("stall_count_reset", stall_count, 32'd0);
`endif
      mem_ready = 1'b1;
      IRVal     = 32'hF8000000;
      reset     = 1'b1;
      #1 chk("release_t0", T0_C, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("ill_t1", T1_C, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("ill_t2", T2_C, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("ill_t3", 30'h0, 16'h0, 16'h0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         #1 chk($sformatf("ill_halted[%0d]", i), C_HALTED | C_ILLEGAL, 16'h0, 16'h0);
      end
`ifdef CONTROL_UNIT_PERF_EN
      chk_val("instr_count_halted", instr_count, 32'd0);
      chk_val("stall_count_halted", stall_count, 32'd0);
`endif

      // HALT: stopped without the illegal flag
      @(negedge clk);
      reset = 1'b0;
      #1 chk("reset_clears_illegal", 30'h0, 16'h0, 16'h0);
      @(negedge clk);
      IRVal     = 32'h78000000;
      mem_ready = 1'b1;
      reset     = 1'b1;
      #1 chk("halt_t0", T0_C, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("halt_t1", T1_C, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("halt_t2", T2_C, 16'h0, 16'h0);
      @(negedge clk);
      #1 chk("halt_t3", 30'h0, 16'h0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 chk($sformatf("halt_halted[%0d]", i), C_HALTED, 16'h0, 16'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
